// File: rtl/fp_square_seq_pkg.sv
// Shared binary32 constants, field widths and the squarer's state encoding.
// Imported by the squarer top level and its multiplier.
package fp32_pkg;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/fp_square_seq_if.sv
// Request/result bundle of the sequential binary32 squarer.
// start is accepted only while busy = 0 and the block is not in DONE.
// done pulses for one cycle with S valid; S then holds until the next done.
interface fp_square_seq_if;
  logic        start;
  logic [31:0] A;
  logic        busy;
  logic        done;
  logic [31:0] S;

  modport master (output start, A, input busy, done, S);
  modport slave  (input start, A, output busy, done, S);
endinterface

// File: rtl/fp_square_seq_mult24.sv
// 24x24 unsigned shift-and-add multiplier: one partial product per cycle.
// load clears the accumulator and starts a 24-step run; last flags the final step.
module seq_mult24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p,
  output logic        last
);
  logic [47:0] acc;
  logic [23:0] mcand;
  logic [23:0] mplier;
  logic [4:0]  cnt;
  logic        run;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0]) acc <= acc + ({24'd0, mcand} << cnt);
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      // The product stays frozen in acc once the run ends.
      if (cnt == 5'd23) run <= 1'b0;
    end
  end

  assign p    = acc;
  assign last = run && (cnt == 5'd23);
endmodule

// File: rtl/fp_square_seq.sv
// Sequential binary32 squarer: FSM, special-case decode, exponent math and
// normalisation around a shift-add mantissa multiplier. Truncating, FTZ, sign always 0.
module fp_square_seq
  import fp32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fp_square_seq_if.slave       bus,
  output logic [1:0]           dbg_state
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MUL  = MUL;
  localparam logic [1:0] ST_NORM = NORM;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state;
  logic [30:0]       a_q;
  logic [31:0]       s_q;
  logic [47:0]       prod;
  logic              last;
  logic              load;
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] frac;
  logic              n;
  logic signed [9:0] exp_calc;
  logic [FRAC_W-1:0] mant;
  logic [31:0]       result;

  assign load = (state == ST_IDLE) && bus.start;

  seq_mult24 u_mult (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .a    ({1'b1, bus.A[22:0]}),
    .b    ({1'b1, bus.A[22:0]}),
    .p    (prod),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      s_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          a_q   <= bus.A[30:0];
          state <= ST_MUL;
        end
        ST_MUL:  if (last) state <= ST_NORM;
        ST_NORM: begin
          s_q   <= result;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // 2e - bias + n: 10-bit signed covers -125..384 without wrap.
  always_comb begin
    e        = a_q[30:23];
    frac     = a_q[22:0];
    n        = prod[47];
    mant     = n ? prod[46:24] : prod[45:23];
    exp_calc = $signed({1'b0, e, 1'b0}) - 10'sd127 + $signed({9'd0, n});
    result   = {1'b0, exp_calc[7:0], mant};
    if (e == 8'(EXP_MAX) && frac != '0)  result = QNAN;
    else if (e == 8'(EXP_MAX))           result = PINF;
    else if (e == '0)                    result = '0;
    else if (exp_calc >= 10'sd255)       result = PINF;
    else if (exp_calc <= 10'sd0)         result = '0;
  end

  assign bus.busy  = (state == ST_MUL) || (state == ST_NORM);
  assign bus.done  = (state == ST_DONE);
  assign bus.S     = s_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_fp_square_seq.sv
// Directed bench for fp_square_seq: hand-computed squares, special cases,
// handshake timing and mid-operation reset.
module tb_fp_square_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [31:0] exp_q[$];

  fp_square_seq_if bus ();

  fp_square_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One full transaction: latency, result and the return to idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] expv, input string tag);
    int lat;
    @(negedge clk);
    bus.A = a;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_q.push_back(expv);
    check({tag, "_latency"}, 32'(lat), 32'd26);
    check({tag, "_S"}, bus.S, exp_q.pop_front());
    @(negedge clk);
    check({tag, "_idle"}, {29'd0, bus.done, bus.busy, bus.start}, 32'd0);
  endtask

  initial begin
    int dcount;
    int d1;
    int d2;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_S", bus.S, 32'h0000_0000);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    run_op(32'h4040_0000, 32'h4110_0000, "sq_3");
    run_op(32'hC040_0000, 32'h4110_0000, "sq_m3");
    run_op(32'h3FC0_0000, 32'h4010_0000, "sq_1p5");
    run_op(32'h4000_0000, 32'h4080_0000, "sq_2");
    run_op(32'h3F80_0001, 32'h3F80_0002, "sq_trunc");
    run_op(32'h7F00_0000, 32'h7F80_0000, "ovf");
    run_op(32'h1F80_0000, 32'h0000_0000, "unf");
    run_op(32'h8000_0000, 32'h0000_0000, "neg_zero");
    run_op(32'h7FC0_0001, 32'h7FC0_0000, "nan");
    run_op(32'hFF80_0000, 32'h7F80_0000, "neg_inf");

    // Extra start pulses during MUL and NORM must be ignored.
    @(negedge clk);
    bus.A = 32'h4040_0000;
    bus.start = 1'b1;
    @(negedge clk);
    dcount = 0;
    d1 = 0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.done) begin
        dcount++;
        d1 = i;
      end
      if (i == 5 || i == 25) begin
        bus.start = 1'b1;
        bus.A = 32'h4000_0000;
      end else begin
        bus.start = 1'b0;
      end
      if (i == 26) check("ignore_S", bus.S, 32'h4110_0000);
      @(negedge clk);
    end
    check("ignore_done_count", 32'(dcount), 32'd1);
    check("ignore_latency", 32'(d1), 32'd26);

    // start held high: requests accepted back to back.
    bus.A = 32'h3FC0_0000;
    bus.start = 1'b1;
    @(negedge clk);
    dcount = 0;
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 70; i++) begin
      if (bus.done) begin
        dcount++;
        if (dcount == 1) d1 = i;
        if (dcount == 2) begin
          d2 = i;
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("b2b_first", 32'(d1), 32'd26);
    check("b2b_spacing", 32'(d2 - d1), 32'd27);
    check("b2b_S", bus.S, 32'h4010_0000);

    // Reset ten cycles into an operation discards it.
    repeat (5) @(negedge clk);
    bus.A = 32'h4040_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_S", bus.S, 32'h0000_0000);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("rst_no_done", 32'(dcount), 32'd0);
    run_op(32'h4040_0000, 32'h4110_0000, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
